id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the pipelined CPU; carries decoded control, operand data, register addresses, shamt, immediate and PC from decode to execute.
- Adds what the plain register lacks: asynchronous reset, stall (hold), flush (bubble insertion), a valid bit with control-side-effect gating, and saturating stall/bubble performance counters.
- Sits between the decode stage and the execute stage; the hazard unit drives its stall and flush inputs.

Parameters:
DATA_W, 32, width of RegData1/RegData2
PC_W, 32, width of PCAddr
IMM_W, 16, width of Imm
RAW, 5, register address width; also the Shamt width
ALUC_W, 5, ALUCtrl width
ALUS_W, 5, ALUSrc width
SEL_W, 2, Mem2RegSEL / RegDstSEL width
CNT_W, 16, performance counter width

Ports:
CLOCK  in  1  clock; all updates on rising edge
RESET  in  1  asynchronous, active-high reset
Stall_In  in  1  hold the current contents
Flush_In  in  1  insert a bubble
Valid_In  in  1  decode-stage instruction valid
CntClr_In  in  1  synchronous clear of both counters
RegWriteEN_In, MemWriteEN_In, Beq_In, Bne_In  in  1 each  control bits
Mem2RegSEL_In, RegDstSEL_In  in  SEL_W  selects
ALUCtrl_In  in  ALUC_W  ALU operation
ALUSrc_In  in  ALUS_W  ALU source control
RegData1_In, RegData2_In  in  DATA_W  operands
RTAddr_In, RDAddr_In, Shamt_In  in  RAW  register addresses and shift amount
Imm_In  in  IMM_W  immediate
PCAddr_In  in  PC_W  PC of the instruction
<each *_In above>_Out  out  same width  registered copy
Valid_Out  out  1  execute-stage instruction valid
StallCnt_Out  out  CNT_W  count of stall cycles
BubbleCnt_Out  out  CNT_W  count of bubbles inserted

Behaviour:
- RESET=1 (asynchronous): every output, including Valid_Out and both counters, goes to 0. This is the NOP state. Release is synchronous to CLOCK.
- Latency: one cycle, In to Out, for a normal load.
- Priority per edge: Flush_In > Stall_In > load.
- Flush: Valid_Out<=0.
  - Control fields <=0: RegWriteEN, MemWriteEN, Beq, Bne, Mem2RegSEL, RegDstSEL, ALUCtrl, ALUSrc.
  - Data fields (RegData1/2, RTAddr, RDAddr, Shamt, Imm, PCAddr) hold their previous value.
- Stall (no flush): all outputs, including Valid_Out, hold.
- Load (no flush, no stall): all fields <= inputs and Valid_Out <= Valid_In.
  - If Valid_In=0, the side-effect bits RegWriteEN_Out, MemWriteEN_Out, Beq_Out and Bne_Out load 0 regardless of their inputs.
  - All other fields load normally when Valid_In=0.
- Invariant: Valid_Out=0 implies RegWriteEN_Out=MemWriteEN_Out=Beq_Out=Bne_Out=0.
- StallCnt: +1 on each edge with Stall_In=1 and Flush_In=0.
- BubbleCnt: +1 on each edge with Flush_In=1, or with a load where Valid_In=0.
- Both counters saturate at 2^CNT_W-1; no wrap.
- CntClr_In=1: both counters <=0 on that edge. This overrides a simultaneous increment. It does not affect the pipeline fields.
- Stall and flush in the same cycle: flush wins; BubbleCnt increments and StallCnt does not.
- RESET asserted mid-stall or mid-flush: outputs go to 0 immediately; the first edge after release behaves per the inputs on that edge.

Decomposition:
- Shared package/header id_ex_pkg holds:
  - default width localparams (DATA_W, PC_W, IMM_W, RAW, ALUC_W, ALUS_W, SEL_W);
  - NOP encodings for ALUCtrl, ALUSrc and the selects (all zero).
- One sub-module, sat_counter (parameter W; ports CLOCK, RESET, Clr, Inc, Count), instantiated twice for the counters.

Test Plan:
- Reset: RESET=1 mid-cycle with all inputs at nonzero values -> every output 0 immediately, without waiting for a CLOCK edge.
- Load: Valid_In=1, RegData1_In=0xDEADBEEF, ALUCtrl_In=5'h0A, RegWriteEN_In=1 -> next edge Out mirrors these and Valid_Out=1.
- Stall: stall 3 cycles while inputs change to RegData1_In=0x12345678 -> Outs stay 0xDEADBEEF/0x0A/1; StallCnt_Out=3; the value loads on the first edge after Stall_In drops.
- Flush with stall: Flush_In=1 and Stall_In=1 together -> Valid_Out=0, all control Outs 0, RegData1_Out unchanged; BubbleCnt +1, StallCnt unchanged.
- Invalid load: Valid_In=0, RegWriteEN_In=1, MemWriteEN_In=1, Beq_In=1 -> those Outs 0, RDAddr_Out loads the input, BubbleCnt +1.
- Counter saturation and clear: CNT_W=4, 20 stall cycles -> StallCnt_Out=15. Then CntClr_In=1 with Stall_In=1 -> StallCnt_Out=0.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths and NOP encodings for the ID/EX pipeline register.
package id_ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned RAW    = 5;
  localparam int unsigned ALUC_W = 5;
  localparam int unsigned ALUS_W = 5;
  localparam int unsigned SEL_W  = 2;

  // A bubble carries these control encodings into execute.
  localparam logic [ALUC_W-1:0] ALUC_NOP = '0;
  localparam logic [ALUS_W-1:0] ALUS_NOP = '0;
  localparam logic [SEL_W-1:0]  SEL_NOP  = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  // Clear beats a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush, valid gating and stall/bubble counters.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = id_ex_pkg::DATA_W,
  parameter int unsigned PC_W   = id_ex_pkg::PC_W,
  parameter int unsigned IMM_W  = id_ex_pkg::IMM_W,
  parameter int unsigned RAW    = id_ex_pkg::RAW,
  parameter int unsigned ALUC_W = id_ex_pkg::ALUC_W,
  parameter int unsigned ALUS_W = id_ex_pkg::ALUS_W,
  parameter int unsigned SEL_W  = id_ex_pkg::SEL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Stall_In,
  input  logic              Flush_In,
  input  logic              Valid_In,
  input  logic              CntClr_In,
  input  logic              RegWriteEN_In,
  input  logic              MemWriteEN_In,
  input  logic              Beq_In,
  input  logic              Bne_In,
  input  logic [SEL_W-1:0]  Mem2RegSEL_In,
  input  logic [SEL_W-1:0]  RegDstSEL_In,
  input  logic [ALUC_W-1:0] ALUCtrl_In,
  input  logic [ALUS_W-1:0] ALUSrc_In,
  input  logic [DATA_W-1:0] RegData1_In,
  input  logic [DATA_W-1:0] RegData2_In,
  input  logic [RAW-1:0]    RTAddr_In,
  input  logic [RAW-1:0]    RDAddr_In,
  input  logic [RAW-1:0]    Shamt_In,
  input  logic [IMM_W-1:0]  Imm_In,
  input  logic [PC_W-1:0]   PCAddr_In,
  output logic              RegWriteEN_Out,
  output logic              MemWriteEN_Out,
  output logic              Beq_Out,
  output logic              Bne_Out,
  output logic [SEL_W-1:0]  Mem2RegSEL_Out,
  output logic [SEL_W-1:0]  RegDstSEL_Out,
  output logic [ALUC_W-1:0] ALUCtrl_Out,
  output logic [ALUS_W-1:0] ALUSrc_Out,
  output logic [DATA_W-1:0] RegData1_Out,
  output logic [DATA_W-1:0] RegData2_Out,
  output logic [RAW-1:0]    RTAddr_Out,
  output logic [RAW-1:0]    RDAddr_Out,
  output logic [RAW-1:0]    Shamt_Out,
  output logic [IMM_W-1:0]  Imm_Out,
  output logic [PC_W-1:0]   PCAddr_Out,
  output logic              Valid_Out,
  output logic [CNT_W-1:0]  StallCnt_Out,
  output logic [CNT_W-1:0]  BubbleCnt_Out
);

  logic stall_inc_c;
  logic bubble_inc_c;

  assign stall_inc_c  = Stall_In & ~Flush_In;
  assign bubble_inc_c = Flush_In | (~Stall_In & ~Valid_In);

  // Flush zeroes control only; data fields keep their last value.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Valid_Out      <= 1'b0;
      RegWriteEN_Out <= 1'b0;
      MemWriteEN_Out <= 1'b0;
      Beq_Out        <= 1'b0;
      Bne_Out        <= 1'b0;
      Mem2RegSEL_Out <= '0;
      RegDstSEL_Out  <= '0;
      ALUCtrl_Out    <= '0;
      ALUSrc_Out     <= '0;
      RegData1_Out   <= '0;
      RegData2_Out   <= '0;
      RTAddr_Out     <= '0;
      RDAddr_Out     <= '0;
      Shamt_Out      <= '0;
      Imm_Out        <= '0;
      PCAddr_Out     <= '0;
    end else if (Flush_In) begin
      Valid_Out      <= 1'b0;
      RegWriteEN_Out <= 1'b0;
      MemWriteEN_Out <= 1'b0;
      Beq_Out        <= 1'b0;
      Bne_Out        <= 1'b0;
      Mem2RegSEL_Out <= SEL_W'(SEL_NOP);
      RegDstSEL_Out  <= SEL_W'(SEL_NOP);
      ALUCtrl_Out    <= ALUC_W'(ALUC_NOP);
      ALUSrc_Out     <= ALUS_W'(ALUS_NOP);
    end else if (!Stall_In) begin
      // Side-effect bits are gated by valid so an invalid slot cannot write or branch.
      Valid_Out      <= Valid_In;
      RegWriteEN_Out <= RegWriteEN_In & Valid_In;
      MemWriteEN_Out <= MemWriteEN_In & Valid_In;
      Beq_Out        <= Beq_In & Valid_In;
      Bne_Out        <= Bne_In & Valid_In;
      Mem2RegSEL_Out <= Mem2RegSEL_In;
      RegDstSEL_Out  <= RegDstSEL_In;
      ALUCtrl_Out    <= ALUCtrl_In;
      ALUSrc_Out     <= ALUSrc_In;
      RegData1_Out   <= RegData1_In;
      RegData2_Out   <= RegData2_In;
      RTAddr_Out     <= RTAddr_In;
      RDAddr_Out     <= RDAddr_In;
      Shamt_Out      <= Shamt_In;
      Imm_Out        <= Imm_In;
      PCAddr_Out     <= PCAddr_In;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .Clr   (CntClr_In),
    .Inc   (stall_inc_c),
    .Count (StallCnt_Out)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .Clr   (CntClr_In),
    .Inc   (bubble_inc_c),
    .Count (BubbleCnt_Out)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed plus random bench for id_ex_stage_reg against a field-level reference model.
module tb_id_ex_stage_reg;

  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic CLOCK, RESET, Stall_In, Flush_In, Valid_In, CntClr_In;
  logic RegWriteEN_In, MemWriteEN_In, Beq_In, Bne_In;
  logic [1:0] Mem2RegSEL_In, RegDstSEL_In;
  logic [4:0] ALUCtrl_In, ALUSrc_In, RTAddr_In, RDAddr_In, Shamt_In;
  logic [31:0] RegData1_In, RegData2_In, PCAddr_In;
  logic [15:0] Imm_In;

  logic RegWriteEN_Out, MemWriteEN_Out, Beq_Out, Bne_Out, Valid_Out;
  logic [1:0] Mem2RegSEL_Out, RegDstSEL_Out;
  logic [4:0] ALUCtrl_Out, ALUSrc_Out, RTAddr_Out, RDAddr_Out, Shamt_Out;
  logic [31:0] RegData1_Out, RegData2_Out, PCAddr_Out;
  logic [15:0] Imm_Out;
  logic [CNT_W-1:0] StallCnt_Out, BubbleCnt_Out;

  // Reference model state: what execute should currently see.
  logic        e_valid;
  logic [3:0]  e_side;
  logic [17:0] e_ctrl;
  logic [31:0] e_d1, e_d2, e_pc;
  logic [14:0] e_addr;
  logic [15:0] e_imm;
  int          e_stall, e_bub;

  int total = 0;
  int bad   = 0;

  id_ex_stage_reg #(.CNT_W(CNT_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Stall_In(Stall_In), .Flush_In(Flush_In),
    .Valid_In(Valid_In), .CntClr_In(CntClr_In),
    .RegWriteEN_In(RegWriteEN_In), .MemWriteEN_In(MemWriteEN_In),
    .Beq_In(Beq_In), .Bne_In(Bne_In),
    .Mem2RegSEL_In(Mem2RegSEL_In), .RegDstSEL_In(RegDstSEL_In),
    .ALUCtrl_In(ALUCtrl_In), .ALUSrc_In(ALUSrc_In),
    .RegData1_In(RegData1_In), .RegData2_In(RegData2_In),
    .RTAddr_In(RTAddr_In), .RDAddr_In(RDAddr_In), .Shamt_In(Shamt_In),
    .Imm_In(Imm_In), .PCAddr_In(PCAddr_In),
    .RegWriteEN_Out(RegWriteEN_Out), .MemWriteEN_Out(MemWriteEN_Out),
    .Beq_Out(Beq_Out), .Bne_Out(Bne_Out),
    .Mem2RegSEL_Out(Mem2RegSEL_Out), .RegDstSEL_Out(RegDstSEL_Out),
    .ALUCtrl_Out(ALUCtrl_Out), .ALUSrc_Out(ALUSrc_Out),
    .RegData1_Out(RegData1_Out), .RegData2_Out(RegData2_Out),
    .RTAddr_Out(RTAddr_Out), .RDAddr_Out(RDAddr_Out), .Shamt_Out(Shamt_Out),
    .Imm_Out(Imm_Out), .PCAddr_Out(PCAddr_Out),
    .Valid_Out(Valid_Out), .StallCnt_Out(StallCnt_Out), .BubbleCnt_Out(BubbleCnt_Out)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 1'b0; e_side = '0; e_ctrl = '0;
    e_d1 = '0; e_d2 = '0; e_pc = '0; e_addr = '0; e_imm = '0;
    e_stall = 0; e_bub = 0;
  endtask

  // One rising edge as the behavioural rules describe it.
  task automatic model_edge();
    if (Flush_In) begin
      e_valid = 1'b0; e_side = '0; e_ctrl = '0;
      e_bub = sat(e_bub + 1);
    end else if (Stall_In) begin
      e_stall = sat(e_stall + 1);
    end else begin
      e_valid = Valid_In;
      e_side  = Valid_In ? {RegWriteEN_In, MemWriteEN_In, Beq_In, Bne_In} : 4'b0;
      e_ctrl  = {Mem2RegSEL_In, RegDstSEL_In, ALUCtrl_In, ALUSrc_In};
      e_d1 = RegData1_In; e_d2 = RegData2_In; e_pc = PCAddr_In;
      e_addr = {RTAddr_In, RDAddr_In, Shamt_In}; e_imm = Imm_In;
      if (!Valid_In) e_bub = sat(e_bub + 1);
    end
    if (CntClr_In) begin
      e_stall = 0; e_bub = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 128'(Valid_Out), 128'(e_valid));
    chk({tag, ".side"}, 128'({RegWriteEN_Out, MemWriteEN_Out, Beq_Out, Bne_Out}), 128'(e_side));
    chk({tag, ".ctrl"}, 128'({Mem2RegSEL_Out, RegDstSEL_Out, ALUCtrl_Out, ALUSrc_Out}), 128'(e_ctrl));
    chk({tag, ".data"}, {64'(RegData1_Out), 64'(RegData2_Out)}, {64'(e_d1), 64'(e_d2)});
    chk({tag, ".addr_imm_pc"}, 128'({RTAddr_Out, RDAddr_Out, Shamt_Out, Imm_Out, PCAddr_Out}),
        128'({e_addr, e_imm, e_pc}));
    chk({tag, ".stallcnt"}, 128'(StallCnt_Out), 128'(e_stall));
    chk({tag, ".bubblecnt"}, 128'(BubbleCnt_Out), 128'(e_bub));
    chk({tag, ".invariant"},
        128'(!Valid_Out && (RegWriteEN_Out || MemWriteEN_Out || Beq_Out || Bne_Out)), 128'(0));
  endtask

  task automatic step(input string tag);
    @(posedge CLOCK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_fields();
    RegWriteEN_In = 1'($urandom); MemWriteEN_In = 1'($urandom);
    Beq_In = 1'($urandom); Bne_In = 1'($urandom);
    Mem2RegSEL_In = 2'($urandom); RegDstSEL_In = 2'($urandom);
    ALUCtrl_In = 5'($urandom); ALUSrc_In = 5'($urandom);
    RegData1_In = $urandom; RegData2_In = $urandom; PCAddr_In = $urandom;
    RTAddr_In = 5'($urandom); RDAddr_In = 5'($urandom); Shamt_In = 5'($urandom);
    Imm_In = 16'($urandom);
  endtask

  task automatic ctl(input logic v, input logic s, input logic f, input logic c);
    Valid_In = v; Stall_In = s; Flush_In = f; CntClr_In = c;
  endtask

  initial begin
    RESET = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_fields();
    model_reset();
    #3;
    check_all("reset_init");
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;

    // Directed load
    rand_fields();
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    RegData1_In = 32'hDEADBEEF; ALUCtrl_In = 5'h0A; RegWriteEN_In = 1'b1;
    step("load");
    chk("load.d1_const", 128'(RegData1_Out), 128'(32'hDEADBEEF));

    // Stall three cycles while the decode side changes
    RegData1_In = 32'h12345678;
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.d1_held", 128'(RegData1_Out), 128'(32'hDEADBEEF));
    chk("stall.cnt3", 128'(StallCnt_Out), 128'(3));
    Stall_In = 1'b0;
    step("stall_release");
    chk("release.d1", 128'(RegData1_Out), 128'(32'h12345678));

    // Flush together with stall
    rand_fields();
    ctl(1'b1, 1'b1, 1'b1, 1'b0);
    step("flush_stall");
    chk("flush.d1_kept", 128'(RegData1_Out), 128'(32'h12345678));

    // Invalid load gates side-effect bits
    rand_fields();
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    RegWriteEN_In = 1'b1; MemWriteEN_In = 1'b1; Beq_In = 1'b1; RDAddr_In = 5'h1B;
    step("invalid_load");
    chk("invalid.rd", 128'(RDAddr_Out), 128'(5'h1B));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      ctl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 30) == 0));
      step("random");
    end

    // Asynchronous reset in the middle of a stall, no clock edge needed
    rand_fields();
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    step("pre_reset_stall");
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge CLOCK);
    RESET = 1'b0;
    rand_fields();
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    step("post_reset_load");

    // Saturation then clear overriding a stall
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_fields();
      step("sat_stall");
    end
    chk("sat.stall15", 128'(StallCnt_Out), 128'(15));
    CntClr_In = 1'b1;
    step("clr_with_stall");
    chk("clr.stall0", 128'(StallCnt_Out), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
